// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//
// Slave end of the core's MEM-stage load/store port. Accepts one request at a
// time, waits WAIT_CYCLES cycles, then performs a little-endian byte/half/word
// store or a sign/zero-extended load against an internal word array. Every
// request, stores included, is answered on the response channel.
//
// Ports
//   clk            clock, all state on the rising edge
//   reset          asynchronous reset, active low
//   req_valid      request present
//   req_ready      responder idle and able to accept
//   req_we         1 = store, 0 = load
//   req_addr       byte address
//   req_wdata      store data, right-aligned
//   req_swhb       store size: 01 byte, 10 half, 11 word, 00 illegal
//   req_lwhb       load size, same encoding
//   req_lunsigned  1 = zero-extend load, 0 = sign-extend
//   resp_valid     response present, held until resp_ready
//   resp_ready     requester takes the response
//   resp_rdata     load result; 0 for stores and errors
//   resp_err       misaligned, out-of-range or illegal-size access
//
// Byte-lane selection comes from addr[1:0], so the lane logic assumes
// XLEN = 32.
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int XLEN        = 32,
    parameter int ADDR_SIZE   = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    input  logic [1:0]           req_swhb,
    input  logic [1:0]           req_lwhb,
    input  logic                 req_lunsigned,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [XLEN-1:0]      resp_rdata,
    output logic                 resp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stateType;

    stateType             stateQ, stateD;
    logic [CNT_W-1:0]     waitCnt;
    logic                 accessEn;
    logic                 reqFire;

    // Captured request fields.
    logic                 capWe;
    logic [ADDR_SIZE-1:0] capAddr;
    logic [XLEN-1:0]      capWdata;
    logic [1:0]           capSwhb;
    logic [1:0]           capLwhb;
    logic                 capUnsigned;

    // Operands of the access. With zero wait states the access happens on the
    // accept edge itself, before the captured copies exist, so IDLE reads the
    // live request inputs.
    logic                 accWe;
    logic [ADDR_SIZE-1:0] accAddr;
    logic [XLEN-1:0]      accWdata;
    logic [1:0]           accSize;
    logic                 accUnsigned;
    logic                 accErr;
    logic                 outOfRange;
    logic [IDX_W-1:0]     memIdx;

    logic [3:0]           byteEn;
    logic [XLEN-1:0]      wdataLane;
    logic [XLEN-1:0]      rawWord;
    logic [7:0]           byteVal;
    logic [15:0]          halfVal;
    logic [XLEN-1:0]      loadData;
    logic                 memWe;

    logic [XLEN-1:0]      mem [DEPTH_WORDS];

    assign reqFire = req_valid && (stateQ == IDLE);

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the values from before the edge, regardless of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        stateD     = stateQ;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accessEn   = 1'b0;
        case (stateQ)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        stateD   = RESP;
                        accessEn = 1'b1;
                    end else begin
                        stateD = WAIT;
                    end
                end
            end
            WAIT: begin
                if (waitCnt == CNT_W'(1)) begin
                    stateD   = RESP;
                    accessEn = 1'b1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    stateD = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------------
    always_comb begin
        if (stateQ == IDLE) begin
            accWe       = req_we;
            accAddr     = req_addr;
            accWdata    = req_wdata;
            accSize     = req_we ? req_swhb : req_lwhb;
            accUnsigned = req_lunsigned;
        end else begin
            accWe       = capWe;
            accAddr     = capAddr;
            accWdata    = capWdata;
            accSize     = capWe ? capSwhb : capLwhb;
            accUnsigned = capUnsigned;
        end
    end

    // Word index is compared at full width so high addresses never alias.
    assign outOfRange = {2'b00, accAddr[ADDR_SIZE-1:2]} >= ADDR_SIZE'(DEPTH_WORDS);
    assign accErr     = (accSize == 2'b00)
                     || (accSize == 2'b10 && accAddr[0])
                     || (accSize == 2'b11 && accAddr[1:0] != 2'b00)
                     || outOfRange;
    assign memIdx     = accAddr[IDX_W+1:2];

    always_comb begin
        byteEn    = 4'b0000;
        wdataLane = accWdata;
        case (accSize)
            2'b01: begin
                byteEn    = 4'b0001 << accAddr[1:0];
                wdataLane = {(XLEN/8){accWdata[7:0]}};
            end
            2'b10: begin
                byteEn    = accAddr[1] ? 4'b1100 : 4'b0011;
                wdataLane = {(XLEN/16){accWdata[15:0]}};
            end
            2'b11:   byteEn = 4'b1111;
            default: byteEn = 4'b0000;
        endcase
    end

    assign rawWord = mem[memIdx];
    assign byteVal = rawWord[8*accAddr[1:0] +: 8];
    assign halfVal = accAddr[1] ? rawWord[31:16] : rawWord[15:0];

    always_comb begin
        loadData = '0;
        case (accSize)
            2'b01:   loadData = {{(XLEN-8){byteVal[7] & ~accUnsigned}}, byteVal};
            2'b10:   loadData = {{(XLEN-16){halfVal[15] & ~accUnsigned}}, halfVal};
            2'b11:   loadData = rawWord;
            default: loadData = '0;
        endcase
    end

    // Gated by reset so a zero-wait store presented during reset never lands.
    assign memWe = accessEn && reset && accWe && !accErr;

    // NOTE: the storage array has no reset; its contents survive reset and
    // it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn[b]) begin
                    mem[memIdx][8*b +: 8] <= wdataLane[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Capture, wait counter and response registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waitCnt     <= '0;
            capWe       <= 1'b0;
            capAddr     <= '0;
            capWdata    <= '0;
            capSwhb     <= 2'b00;
            capLwhb     <= 2'b00;
            capUnsigned <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
        end else begin
            if (reqFire) begin
                waitCnt     <= CNT_W'(WAIT_CYCLES);
                capWe       <= req_we;
                capAddr     <= req_addr;
                capWdata    <= req_wdata;
                capSwhb     <= req_swhb;
                capLwhb     <= req_lwhb;
                capUnsigned <= req_lunsigned;
            end else if (stateQ == WAIT) begin
                waitCnt <= waitCnt - CNT_W'(1);
            end
            // Response registers change only on the access edge, which keeps
            // them stable for as long as the requester stalls in RESP.
            if (accessEn) begin
                resp_err   <= accErr;
                resp_rdata <= (accErr || accWe) ? '0 : loadData;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
//
// Drives two responders, one with two wait states and one with none, through
// shared request wires; useZero picks which one sees req_valid and whose
// outputs are observed. Expected load data comes from a byte-array model of
// each responder's low memory, plus literal values for the directed cases.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam logic [31:0] OOR_ADDR = 32'(DEPTH * 4);

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] expRd;
        logic        expErr;
    } rowT;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqValid, reqWe, reqLunsigned, respReady;
    logic [31:0] reqAddr, reqWdata;
    logic [1:0]  reqSwhb, reqLwhb;
    logic        useZero;

    logic        v2, rdy2, rvalid2, err2;
    logic        v0, rdy0, rvalid0, err0;
    logic [31:0] rdata2, rdata0;
    logic        rdy, rvalid, err;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;

    // Byte model of addresses 0..63 for each responder (index = useZero).
    logic [7:0] refMem [2][64];

    always #5 clk = ~clk;

    assign v2     = reqValid & ~useZero;
    assign v0     = reqValid & useZero;
    assign rdy    = useZero ? rdy0 : rdy2;
    assign rvalid = useZero ? rvalid0 : rvalid2;
    assign rdata  = useZero ? rdata0 : rdata2;
    assign err    = useZero ? err0 : err2;

    dmem_responder #(.XLEN(32), .ADDR_SIZE(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset),
        .req_valid(v2), .req_ready(rdy2), .req_we(reqWe), .req_addr(reqAddr),
        .req_wdata(reqWdata), .req_swhb(reqSwhb), .req_lwhb(reqLwhb),
        .req_lunsigned(reqLunsigned),
        .resp_valid(rvalid2), .resp_ready(respReady), .resp_rdata(rdata2), .resp_err(err2)
    );

    dmem_responder #(.XLEN(32), .ADDR_SIZE(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(v0), .req_ready(rdy0), .req_we(reqWe), .req_addr(reqAddr),
        .req_wdata(reqWdata), .req_swhb(reqSwhb), .req_lwhb(reqLwhb),
        .req_lunsigned(reqLunsigned),
        .resp_valid(rvalid0), .resp_ready(respReady), .resp_rdata(rdata0), .resp_err(err0)
    );

    function automatic int curLat();
        return useZero ? 1 : 3;
    endfunction

    // Reference model: size in bytes, alignment by modulo, little-endian bytes.
    task automatic refAccess(input int d, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [1:0] sz, input logic uns,
                             output logic expErr, output logic [31:0] expRd);
        int n;
        case (sz)
            2'd1:    n = 1;
            2'd2:    n = 2;
            2'd3:    n = 4;
            default: n = 0;
        endcase
        expRd = '0;
        if (n == 0) expErr = 1'b1;
        else        expErr = (addr % n != 0) || (addr / 4 >= DEPTH);
        if (!expErr && addr < 64) begin
            if (we) begin
                for (int i = 0; i < n; i++) refMem[d][int'(addr) + i] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) expRd[8*i +: 8] = refMem[d][int'(addr) + i];
                if (!uns && n < 4 && expRd[8*n-1])
                    for (int i = n; i < 4; i++) expRd[8*i +: 8] = 8'hFF;
            end
        end
    endtask

    // Runs one transaction; returns what was observed. proto reports whether
    // req_ready/resp_valid and response stability behaved throughout.
    task automatic doReq(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] sw, input logic [1:0] lw, input logic uns,
                         input int hold, output logic [31:0] rd, output logic er,
                         output int lat, output logic proto);
        proto = 1'b1; lat = -1; rd = '0; er = 1'b0;
        @(negedge clk);
        reqWe = we; reqAddr = addr; reqWdata = wdata;
        reqSwhb = sw; reqLwhb = lw; reqLunsigned = uns; reqValid = 1'b1;
        if (rdy !== 1'b1) proto = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // Scramble the fields after accept: the responder must use its copies.
        reqValid = 1'b0;
        reqWe = 1'($urandom_range(0, 1)); reqAddr = $urandom; reqWdata = $urandom;
        reqSwhb = 2'($urandom_range(0, 3)); reqLwhb = 2'($urandom_range(0, 3));
        reqLunsigned = 1'($urandom_range(0, 1));
        for (int k = 0; k < 30; k++) begin
            if (rvalid === 1'b1) begin
                lat = k + 1;
                break;
            end
            if (rdy !== 1'b0) proto = 1'b0;
            @(negedge clk);
        end
        if (lat < 0) return;
        rd = rdata; er = err;
        if (rdy !== 1'b0) proto = 1'b0;
        if (hold > 0) begin
            respReady = 1'b0;
            repeat (hold) begin
                @(negedge clk);
                if (rvalid !== 1'b1 || rdata !== rd || err !== er || rdy !== 1'b0) proto = 1'b0;
            end
            respReady = 1'b1;
        end
        @(negedge clk);
        if (rvalid !== 1'b0 || rdy !== 1'b1) proto = 1'b0;
    endtask

    // Updates the model and runs the row on the selected responder.
    task automatic driveRow(input rowT r, input int hold, output logic [31:0] rd,
                            output logic er, output int lat, output logic proto,
                            output logic [31:0] mRd, output logic mErr);
        refAccess(int'(useZero), r.we, r.addr, r.wdata, r.sz, r.uns, mErr, mRd);
        doReq(r.we, r.addr, r.wdata, r.we ? r.sz : ~r.sz, r.we ? ~r.sz : r.sz,
              r.uns, hold, rd, er, lat, proto);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({rdy2, rvalid2, err2, rdata2} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_wait2: ready=%b valid=%b err=%b rdata=%h, want 1 0 0 00000000",
                     rdy2, rvalid2, err2, rdata2);
        end
        checks++;
        if ({rdy0, rvalid0, err0, rdata0} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_wait0: ready=%b valid=%b err=%b rdata=%h, want 1 0 0 00000000",
                     rdy0, rvalid0, err0, rdata0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_init();
        rowT r; logic [31:0] rd, mRd; logic er, mErr, proto; int lat;
        for (int d = 0; d < 2; d++) begin
            useZero = 1'(d);
            for (int w = 0; w < 16; w++) begin
                r = '{1'b1, 32'(4 * w), $urandom, 2'b11, 1'b0, 32'h0, 1'b0};
                driveRow(r, 0, rd, er, lat, proto, mRd, mErr);
                checks++;
                if (er !== 1'b0 || rd !== 32'h0 || lat !== curLat() || proto !== 1'b1) begin
                    errors++;
                    $display("FAIL init[%0d/%0d]: rdata=%h err=%b lat=%0d proto=%b, want 0 0 %0d 1",
                             d, w, rd, er, lat, proto, curLat());
                end
            end
        end
        useZero = 1'b0;
    endtask

    task automatic test_word_store_load();
        rowT rows [2]; logic [31:0] rd, mRd; logic er, mErr, proto; int lat;
        rows[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 2'b11, 1'b0, 32'h0, 1'b0};
        rows[1] = '{1'b0, 32'h10, 32'h0, 2'b11, 1'b1, 32'hDEADBEEF, 1'b0};
        for (int i = 0; i < 2; i++) begin
            driveRow(rows[i], 0, rd, er, lat, proto, mRd, mErr);
            checks++;
            if (rd !== rows[i].expRd || er !== rows[i].expErr || lat !== curLat() || proto !== 1'b1) begin
                errors++;
                $display("FAIL word_store_load[%0d]: rdata=%h err=%b lat=%0d proto=%b, want %h %b %0d 1",
                         i, rd, er, lat, proto, rows[i].expRd, rows[i].expErr, curLat());
            end
        end
    endtask

    task automatic test_extension();
        rowT rows [5]; logic [31:0] rd, mRd; logic er, mErr, proto; int lat;
        rows[0] = '{1'b0, 32'h13, 32'h0, 2'b01, 1'b0, 32'hFFFFFFDE, 1'b0};
        rows[1] = '{1'b0, 32'h13, 32'h0, 2'b01, 1'b1, 32'h000000DE, 1'b0};
        rows[2] = '{1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hFFFFBEEF, 1'b0};
        rows[3] = '{1'b1, 32'h11, 32'hFFFFFF5A, 2'b01, 1'b0, 32'h0, 1'b0};
        rows[4] = '{1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'hDEAD5AEF, 1'b0};
        for (int i = 0; i < 5; i++) begin
            driveRow(rows[i], 0, rd, er, lat, proto, mRd, mErr);
            checks++;
            if (rd !== rows[i].expRd || er !== rows[i].expErr || lat !== curLat() || proto !== 1'b1) begin
                errors++;
                $display("FAIL extension[%0d]: rdata=%h err=%b lat=%0d proto=%b, want %h %b %0d 1",
                         i, rd, er, lat, proto, rows[i].expRd, rows[i].expErr, curLat());
            end
        end
    endtask

    task automatic test_errors();
        rowT rows [6]; logic [31:0] rd, mRd; logic er, mErr, proto; int lat;
        rows[0] = '{1'b0, 32'h12, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1};
        rows[1] = '{1'b1, 32'h11, 32'h0000AAAA, 2'b10, 1'b0, 32'h0, 1'b1};
        rows[2] = '{1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'hDEAD5AEF, 1'b0};
        rows[3] = '{1'b0, OOR_ADDR, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1};
        rows[4] = '{1'b1, 32'h10, 32'h12345678, 2'b00, 1'b0, 32'h0, 1'b1};
        rows[5] = '{1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'hDEAD5AEF, 1'b0};
        for (int i = 0; i < 6; i++) begin
            driveRow(rows[i], 0, rd, er, lat, proto, mRd, mErr);
            checks++;
            if (rd !== rows[i].expRd || er !== rows[i].expErr || lat !== curLat() || proto !== 1'b1) begin
                errors++;
                $display("FAIL errors[%0d]: rdata=%h err=%b lat=%0d proto=%b, want %h %b %0d 1",
                         i, rd, er, lat, proto, rows[i].expRd, rows[i].expErr, curLat());
            end
        end
    endtask

    task automatic test_backpressure();
        rowT r; logic [31:0] rd, mRd; logic er, mErr, proto; int lat;
        r = '{1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'hDEAD5AEF, 1'b0};
        driveRow(r, 5, rd, er, lat, proto, mRd, mErr);
        checks++;
        if (rd !== r.expRd || er !== 1'b0 || lat !== curLat() || proto !== 1'b1) begin
            errors++;
            $display("FAIL backpressure: rdata=%h err=%b lat=%0d stable=%b, want %h 0 %0d 1",
                     rd, er, lat, proto, r.expRd, curLat());
        end
    endtask

    task automatic test_zero_wait();
        rowT rows [4]; logic [31:0] rd, mRd; logic er, mErr, proto; int lat;
        useZero = 1'b1;
        rows[0] = '{1'b1, 32'h08, 32'hCAFEF00D, 2'b11, 1'b0, 32'h0, 1'b0};
        rows[1] = '{1'b0, 32'h08, 32'h0, 2'b11, 1'b0, 32'hCAFEF00D, 1'b0};
        rows[2] = '{1'b0, 32'h0A, 32'h0, 2'b10, 1'b0, 32'hFFFFCAFE, 1'b0};
        rows[3] = '{1'b0, 32'h09, 32'h0, 2'b01, 1'b1, 32'h000000F0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            driveRow(rows[i], 0, rd, er, lat, proto, mRd, mErr);
            checks++;
            if (rd !== rows[i].expRd || er !== rows[i].expErr || lat !== 1 || proto !== 1'b1) begin
                errors++;
                $display("FAIL zero_wait[%0d]: rdata=%h err=%b lat=%0d proto=%b, want %h %b 1 1",
                         i, rd, er, lat, proto, rows[i].expRd, rows[i].expErr);
            end
        end
    endtask

    // With zero wait states and resp_ready held, a held request is accepted
    // on every other edge: ready and valid alternate.
    task automatic test_back_to_back();
        logic expRdy;
        useZero = 1'b1;
        @(negedge clk);
        reqWe = 1'b0; reqAddr = 32'h08; reqLwhb = 2'b11; reqSwhb = 2'b00;
        reqLunsigned = 1'b0; respReady = 1'b1; reqValid = 1'b1;
        for (int e = 0; e < 6; e++) begin
            expRdy = (e % 2 == 0);
            checks++;
            if (rdy !== expRdy || rvalid !== !expRdy || (!expRdy && rdata !== 32'hCAFEF00D)) begin
                errors++;
                $display("FAIL back_to_back[%0d]: ready=%b valid=%b rdata=%h, want ready=%b valid=%b",
                         e, rdy, rvalid, rdata, expRdy, !expRdy);
            end
            @(negedge clk);
        end
        checks++;
        if (rdy !== 1'b1 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_end: ready=%b valid=%b, want 1 0", rdy, rvalid);
        end
        reqValid = 1'b0;
        @(negedge clk);
        useZero = 1'b0;
    endtask

    task automatic test_reset_abort();
        rowT r; logic [31:0] rd, mRd; logic er, mErr, proto; int lat; logic quiet;
        useZero = 1'b0;
        r = '{1'b1, 32'h20, 32'h22222222, 2'b11, 1'b0, 32'h0, 1'b0};
        driveRow(r, 0, rd, er, lat, proto, mRd, mErr);
        r = '{1'b0, 32'h20, 32'h0, 2'b11, 1'b0, 32'h22222222, 1'b0};
        driveRow(r, 0, rd, er, lat, proto, mRd, mErr);
        checks++;
        if (rd !== 32'h22222222 || er !== 1'b0) begin
            errors++;
            $display("FAIL abort_prefill: rdata=%h err=%b, want 22222222 0", rd, er);
        end
        // Store that will be aborted in WAIT; the model is deliberately not told.
        @(negedge clk);
        reqWe = 1'b1; reqAddr = 32'h20; reqWdata = 32'h11111111;
        reqSwhb = 2'b11; reqLwhb = 2'b11; reqValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({rdy2, rvalid2, err2, rdata2} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL abort_async: ready=%b valid=%b err=%b rdata=%h, want 1 0 0 00000000",
                     rdy2, rvalid2, err2, rdata2);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        quiet = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (rvalid2 !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin
            errors++;
            $display("FAIL abort_no_response: a response appeared after reset, want none");
        end
        r = '{1'b0, 32'h20, 32'h0, 2'b11, 1'b0, 32'h22222222, 1'b0};
        driveRow(r, 0, rd, er, lat, proto, mRd, mErr);
        checks++;
        if (rd !== 32'h22222222 || er !== 1'b0 || lat !== 3 || proto !== 1'b1) begin
            errors++;
            $display("FAIL abort_persist: rdata=%h err=%b lat=%0d proto=%b, want 22222222 0 3 1",
                     rd, er, lat, proto);
        end
    endtask

    task automatic test_random();
        rowT r; logic [31:0] rd, mRd, addr; logic er, mErr, proto; int lat; int sel;
        for (int d = 0; d < 2; d++) begin
            useZero = 1'(d);
            for (int n = 0; n < 60; n++) begin
                sel = $urandom_range(0, 9);
                if (sel == 0)      addr = OOR_ADDR + 32'($urandom_range(0, 15));
                else if (sel == 1) addr = $urandom | 32'h8000_0000;
                else               addr = 32'($urandom_range(0, 63));
                r = '{1'($urandom_range(0, 1)), addr, $urandom, 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 32'h0, 1'b0};
                driveRow(r, 0, rd, er, lat, proto, mRd, mErr);
                checks++;
                if (rd !== mRd || er !== mErr || lat !== curLat() || proto !== 1'b1) begin
                    errors++;
                    $display("FAIL random[%0d/%0d] we=%b addr=%h sz=%b uns=%b: rdata=%h err=%b lat=%0d proto=%b, want %h %b %0d 1",
                             d, n, r.we, r.addr, r.sz, r.uns, rd, er, lat, proto, mRd, mErr, curLat());
                end
            end
        end
        useZero = 1'b0;
    endtask

    initial begin
        reqValid = 1'b0; reqWe = 1'b0; reqAddr = '0; reqWdata = '0;
        reqSwhb = 2'b00; reqLwhb = 2'b00; reqLunsigned = 1'b0;
        respReady = 1'b1; useZero = 1'b0;
        test_reset();
        test_init();
        test_word_store_load();
        test_extension();
        test_errors();
        test_backpressure();
        test_zero_wait();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined core: the slave end of the load/store port the datapath drives in its MEM stage. Accepts one request at a time over a valid/ready handshake and performs byte/half/word little-endian writes or sign/zero-extended reads. Inserts a programmable number of wait states, so the core and its hazard logic can be exercised against non-zero memory latency. Returns every result, including write acknowledgements, on a separate valid/ready response channel.

## Interface
- XLEN, 32, data width
- ADDR_SIZE, 32, byte-address width
- DEPTH_WORDS, 1024, storage depth in XLEN-bit words (power of two)
- WAIT_CYCLES, 2, wait states between accept and access (0 allowed)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_SIZE  byte address
- req_wdata  in  XLEN  store data, right-aligned
- req_swhb  in  2  store size: 01 byte, 10 half, 11 word, 00 illegal
- req_lwhb  in  2  load size, same encoding
- req_lunsigned  in  1  1 = zero-extend load, 0 = sign-extend
- resp_valid  out  1  response present
- resp_ready  in  1  requester takes response
- resp_rdata  out  XLEN  load result; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-range or illegal-size access

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture we/addr/wdata/size/lunsigned and load wait counter with WAIT_CYCLES.
  - If WAIT_CYCLES==0, go to RESP; otherwise go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - Leave for RESP on the edge where counter==1.
- Access happens on the edge entering RESP:
  - Store writes enabled byte lanes only.
  - Load latches extended data into resp_rdata.
- RESP:
  - resp_valid=1; resp_rdata/resp_err held stable until resp_ready=1.
  - On that edge, go to IDLE.
- req_ready=0 in WAIT and RESP. A request is never accepted in the same cycle a response is taken.
- Size: word = 11, half = 10, byte = 01.
- Lane select uses addr[1:0]; byte k occupies bits 8k+7:8k (little-endian).
- Errors (resp_err=1, no array write, resp_rdata=0):
  - size 00;
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - word index addr[ADDR_SIZE-1:2] ≥ DEPTH_WORDS. No wrap-around.
- Load extension: byte/half bit 7/15 is replicated when req_lunsigned=0, zero-filled otherwise. Word loads ignore req_lunsigned.
- Store data: byte uses wdata[7:0], half uses wdata[15:0], both replicated to the selected lane(s).
- Memory array is not reset; contents persist across reset.

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
- Reset asserted mid-transaction aborts it:
  - A store not yet reached RESP is not performed.
  - No response is ever issued for the aborted request.
- Handshake at edge N (req_valid & req_ready) gives resp_valid=1 from edge N+WAIT_CYCLES+1.
- Minimum occupancy is WAIT_CYCLES+2 cycles per access when resp_ready is held 1.
- Requester holds request fields only until accept; responder uses captured copies.
- A load immediately after a store to the same address returns the new data, because the store completes before the next accept.
- Request inputs in WAIT/RESP are ignored.

## Test plan
- Word store/load, WAIT_CYCLES=2:
  - Store 0xDEADBEEF @0x10, accepted edge N -> resp_valid at N+3, resp_err=0.
  - Load @0x10 -> resp_rdata=0xDEADBEEF.
- Byte and half extension:
  - After the word store, signed byte load @0x13 -> 0xFFFFFFDE.
  - Unsigned byte load @0x13 -> 0x000000DE.
  - Signed half load @0x10 -> 0xFFFFBEEF.
  - Store byte 0x5A @0x11, then word load @0x10 -> 0xDEAD5AEF.
- Errors:
  - Word load @0x12 -> resp_err=1, resp_rdata=0.
  - Half store @0x11 -> resp_err=1; a following word load @0x10 is unchanged.
  - Load @DEPTH_WORDS*4 -> resp_err=1.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_rdata and resp_err stable, req_ready=0 throughout; release -> IDLE next edge.
- WAIT_CYCLES=0: accept at N -> resp_valid at N+1; back-to-back requests with resp_ready=1 are accepted every 2 cycles.
- Reset mid-WAIT of a store of 0x11111111 @0x20 (prior content 0x22222222):
  - Outputs return to reset values asynchronously.
  - After release, load @0x20 -> 0x22222222.
